// File: rtl/fpu_inflight_tracker.sv
// Tracks the FP destination of each pipelined FP op from EX entry to writeback, exposing six slot outputs for HRU RAW checks.
// Optional checking: define FPU_INFLIGHT_CHECK_EN to enable the sticky o_error flag.
module fpu_inflight_tracker #(
  parameter int NUM_SLOTS = 6,
  parameter int LAT_W     = 3,
  parameter int MAX_LAT   = 7
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_issue_valid,
  input  logic [4:0]           i_issue_dest,
  input  logic [LAT_W-1:0]     i_issue_latency,
  input  logic                 i_advance,
  input  logic                 i_flush,
  output logic [4:0]           o_inflight_dest_1,
  output logic [4:0]           o_inflight_dest_2,
  output logic [4:0]           o_inflight_dest_3,
  output logic [4:0]           o_inflight_dest_4,
  output logic [4:0]           o_inflight_dest_5,
  output logic [4:0]           o_inflight_dest_6,
  output logic                 o_full,
  output logic [NUM_SLOTS-1:0] o_retire_mask,
  output logic [4:0]           o_retire_dest_1,
  output logic [4:0]           o_retire_dest_2,
  output logic [4:0]           o_retire_dest_3,
  output logic [4:0]           o_retire_dest_4,
  output logic [4:0]           o_retire_dest_5,
  output logic [4:0]           o_retire_dest_6,
  output logic                 o_error
);

  logic [4:0]           r_dest        [NUM_SLOTS];
  logic [LAT_W-1:0]     r_cnt         [NUM_SLOTS];
  logic [4:0]           r_retire_dest [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_retire_mask;

  logic [NUM_SLOTS-1:0] w_occupied;
  logic [NUM_SLOTS-1:0] w_retire;
  logic [NUM_SLOTS-1:0] w_free_after;
  logic [NUM_SLOTS-1:0] w_alloc;
  logic                 w_issue;
  logic [LAT_W-1:0]     w_eff_lat;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign w_occupied[gi]   = (r_dest[gi] != 5'd0);
      assign w_retire[gi]     = i_advance && w_occupied[gi] && (r_cnt[gi] == LAT_W'(1));
      // A slot retiring on this edge is already free for this edge's issue.
      assign w_free_after[gi] = !w_occupied[gi] || w_retire[gi];
    end
  endgenerate

  assign w_issue   = i_issue_valid && (i_issue_dest != 5'd0) && !i_flush;
  assign w_eff_lat = (i_issue_latency == '0) ? LAT_W'(1) : i_issue_latency;
  // Isolate the lowest set bit: lowest-index free slot wins.
  assign w_alloc   = w_issue ? (w_free_after & (~w_free_after + NUM_SLOTS'(1))) : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_retire_mask <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        r_dest[k]        <= 5'd0;
        r_cnt[k]         <= '0;
        r_retire_dest[k] <= 5'd0;
      end
    end else if (i_flush) begin
      r_retire_mask <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        r_dest[k] <= 5'd0;
        r_cnt[k]  <= '0;
      end
    end else begin
      r_retire_mask <= w_retire;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (w_retire[k]) begin
          r_retire_dest[k] <= r_dest[k];
        end
        if (w_alloc[k]) begin
          r_dest[k] <= i_issue_dest;
          r_cnt[k]  <= w_eff_lat;
        end else if (w_retire[k]) begin
          r_dest[k] <= 5'd0;
          r_cnt[k]  <= '0;
        end else if (i_advance && w_occupied[k]) begin
          r_cnt[k]  <= r_cnt[k] - LAT_W'(1);
        end
      end
    end
  end

`ifdef FPU_INFLIGHT_CHECK_EN
  logic r_error;
  logic w_err_set;

  assign w_err_set = i_issue_valid && (i_issue_dest != 5'd0) &&
                     ((!i_flush && (w_free_after == '0)) ||
                      (i_issue_latency == '0) ||
                      (int'(i_issue_latency) > MAX_LAT));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_error <= 1'b0;
    end else if (w_err_set) begin
      r_error <= 1'b1;
    end
  end

  assign o_error = r_error;
`else
  assign o_error = 1'b0;
`endif

  // Slot outputs are fixed at six; NUM_SLOTS must stay 6.
  assign o_full            = &w_occupied;
  assign o_retire_mask     = r_retire_mask;
  assign o_inflight_dest_1 = r_dest[0];
  assign o_inflight_dest_2 = r_dest[1];
  assign o_inflight_dest_3 = r_dest[2];
  assign o_inflight_dest_4 = r_dest[3];
  assign o_inflight_dest_5 = r_dest[4];
  assign o_inflight_dest_6 = r_dest[5];
  assign o_retire_dest_1   = r_retire_dest[0];
  assign o_retire_dest_2   = r_retire_dest[1];
  assign o_retire_dest_3   = r_retire_dest[2];
  assign o_retire_dest_4   = r_retire_dest[3];
  assign o_retire_dest_5   = r_retire_dest[4];
  assign o_retire_dest_6   = r_retire_dest[5];

endmodule

// File: tb/tb_fpu_inflight_tracker.sv
// Self-checking bench for fpu_inflight_tracker: directed scenarios plus randomized traffic against an op-level model.
module tb_fpu_inflight_tracker;
  localparam int N = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv = 1'b0, adv = 1'b0, fl = 1'b0;
  logic [4:0] idest = 5'd0;
  logic [2:0] ilat = 3'd0;

  logic [4:0] d1, d2, d3, d4, d5, d6, r1, r2, r3, r4, r5, r6;
  logic       full, err;
  logic [5:0] rmask;
  logic [4:0] dut_inf [N];
  logic [4:0] dut_rd  [N];

  int checks = 0;
  int errors = 0;

  // Model: one record per in-flight op, with advancing edges left until writeback.
  int         m_dest  [N];
  int         m_rem   [N];
  int         m_rdest [N];
  logic [5:0] m_mask;
  logic       m_err;

  always #5 clk = ~clk;

  fpu_inflight_tracker #(.NUM_SLOTS(6), .LAT_W(3), .MAX_LAT(7)) dut (
    .i_clk(clk), .i_rst(rst), .i_issue_valid(iv), .i_issue_dest(idest),
    .i_issue_latency(ilat), .i_advance(adv), .i_flush(fl),
    .o_inflight_dest_1(d1), .o_inflight_dest_2(d2), .o_inflight_dest_3(d3),
    .o_inflight_dest_4(d4), .o_inflight_dest_5(d5), .o_inflight_dest_6(d6),
    .o_full(full), .o_retire_mask(rmask),
    .o_retire_dest_1(r1), .o_retire_dest_2(r2), .o_retire_dest_3(r3),
    .o_retire_dest_4(r4), .o_retire_dest_5(r5), .o_retire_dest_6(r6),
    .o_error(err)
  );

  always_comb begin
    dut_inf[0] = d1; dut_inf[1] = d2; dut_inf[2] = d3;
    dut_inf[3] = d4; dut_inf[4] = d5; dut_inf[5] = d6;
    dut_rd[0]  = r1; dut_rd[1]  = r2; dut_rd[2]  = r3;
    dut_rd[3]  = r4; dut_rd[4]  = r5; dut_rd[5]  = r6;
  end

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_dest[k] = 0; m_rem[k] = 0; m_rdest[k] = 0;
    end
    m_mask = 6'd0;
    m_err  = 1'b0;
  endfunction

  function automatic void model_edge();
    bit placed;
    if (iv && idest != 0 && ilat == 0) m_err = 1'b1;
    if (fl) begin
      for (int k = 0; k < N; k++) begin m_dest[k] = 0; m_rem[k] = 0; end
      m_mask = 6'd0;
    end else begin
      m_mask = 6'd0;
      if (adv) begin
        for (int k = 0; k < N; k++) begin
          if (m_dest[k] != 0) begin
            m_rem[k] = m_rem[k] - 1;
            if (m_rem[k] == 0) begin
              m_mask[k] = 1'b1; m_rdest[k] = m_dest[k]; m_dest[k] = 0;
            end
          end
        end
      end
      if (iv && idest != 0) begin
        placed = 0;
        for (int k = 0; k < N; k++) begin
          if (!placed && m_dest[k] == 0) begin
            m_dest[k] = idest;
            m_rem[k]  = (ilat == 0) ? 1 : int'(ilat);
            placed = 1;
          end
        end
        if (!placed) m_err = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input int d, input int l, input logic a, input logic f);
    iv = v; idest = 5'(d); ilat = 3'(l); adv = a; fl = f;
  endtask

  task automatic reset_dut();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (dut_inf[k] !== 5'd0 || dut_rd[k] !== 5'd0) begin
        errors++; $display("FAIL reset_slot%0d got dest %0d rdest %0d want 0 0", k + 1, dut_inf[k], dut_rd[k]);
      end
    end
    checks++;
    if (full !== 1'b0 || rmask !== 6'd0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_flags got full %b mask %b err %b want 0 000000 0", full, rmask, err);
    end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    reset_dut();
    drive(1, 5, 4, 1, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (d1 !== 5'd5 || rmask !== 6'd0) begin
        errors++; $display("FAIL single_visible cycle%0d got slot1 %0d mask %b want 5 000000", c, d1, rmask);
      end
      tick();
    end
    checks++;
    if (rmask !== 6'b000001 || r1 !== 5'd5 || d1 !== 5'd0) begin
      errors++; $display("FAIL single_retire got mask %b rdest1 %0d slot1 %0d want 000001 5 0", rmask, r1, d1);
    end
    tick();
    checks++;
    if (rmask !== 6'd0) begin
      errors++; $display("FAIL single_pulse got mask %b want 000000", rmask);
    end
    $display("test_single done");
  endtask

  task automatic test_stall();
    reset_dut();
    drive(1, 3, 2, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (d1 !== 5'd3 || rmask !== 6'd0) begin
        errors++; $display("FAIL stall_hold cycle%0d got slot1 %0d mask %b want 3 000000", c, d1, rmask);
      end
    end
    adv = 1'b1;
    tick();
    checks++;
    if (d1 !== 5'd3 || rmask !== 6'd0) begin
      errors++; $display("FAIL stall_first_adv got slot1 %0d mask %b want 3 000000", d1, rmask);
    end
    tick();
    checks++;
    if (d1 !== 5'd0 || rmask !== 6'b000001 || r1 !== 5'd3) begin
      errors++; $display("FAIL stall_retire got slot1 %0d mask %b rdest1 %0d want 0 000001 3", d1, rmask, r1);
    end
    $display("test_stall done");
  endtask

  task automatic test_fill_drop();
    reset_dut();
    for (int i = 1; i <= 6; i++) begin
      drive(1, i, 7, 1, 0);
      tick();
    end
    checks++;
    if (full !== 1'b1) begin
      errors++; $display("FAIL fill_full got %b want 1", full);
    end
    drive(1, 9, 7, 1, 0);
    tick();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (dut_inf[k] !== 5'(k + 1)) begin
        errors++; $display("FAIL drop_slot%0d got %0d want %0d", k + 1, dut_inf[k], k + 1);
      end
    end
    checks++;
`ifdef FPU_INFLIGHT_CHECK_EN
    if (err !== 1'b1) begin errors++; $display("FAIL drop_error got %b want 1", err); end
`else
    if (err !== 1'b0) begin errors++; $display("FAIL drop_error got %b want 0", err); end
`endif
    drive(0, 0, 0, 1, 0);
    tick();
    checks++;
    if (rmask !== 6'b000001 || r1 !== 5'd1 || d1 !== 5'd0 || full !== 1'b0) begin
      errors++; $display("FAIL fill_retire got mask %b rdest1 %0d slot1 %0d full %b want 000001 1 0 0", rmask, r1, d1, full);
    end
    drive(1, 9, 3, 1, 0);
    tick();
    checks++;
    if (d1 !== 5'd9) begin
      errors++; $display("FAIL fill_reissue got slot1 %0d want 9", d1);
    end
    $display("test_fill_drop done");
  endtask

  task automatic test_back_to_back();
    reset_dut();
    drive(1, 2, 6, 1, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 10 + i, 7, 1, 0);
      tick();
    end
    checks++;
    if (full !== 1'b1 || d1 !== 5'd2) begin
      errors++; $display("FAIL reuse_pre got full %b slot1 %0d want 1 2", full, d1);
    end
    drive(1, 8, 3, 1, 0);
    tick();
    checks++;
    if (rmask !== 6'b000001 || r1 !== 5'd2 || d1 !== 5'd8 || d2 !== 5'd10 || full !== 1'b1) begin
      errors++; $display("FAIL reuse_same_edge got mask %b rdest1 %0d slot1 %0d slot2 %0d full %b want 000001 2 8 10 1",
                         rmask, r1, d1, d2, full);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_flush();
    reset_dut();
    drive(1, 7, 3, 1, 0);  tick();
    drive(1, 11, 5, 1, 0); tick();
    drive(1, 13, 5, 1, 0); tick();
    checks++;
    if (d1 !== 5'd7 || d2 !== 5'd11 || d3 !== 5'd13) begin
      errors++; $display("FAIL flush_pre got %0d %0d %0d want 7 11 13", d1, d2, d3);
    end
    drive(1, 4, 3, 1, 1);
    tick();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (dut_inf[k] !== 5'd0) begin
        errors++; $display("FAIL flush_slot%0d got %0d want 0", k + 1, dut_inf[k]);
      end
    end
    checks++;
    if (rmask !== 6'd0) begin
      errors++; $display("FAIL flush_mask got %b want 000000", rmask);
    end
    $display("test_flush done");
  endtask

  task automatic test_dest0_async();
    reset_dut();
    drive(1, 0, 3, 1, 0);
    tick();
    checks++;
    if (d1 !== 5'd0 || d2 !== 5'd0 || full !== 1'b0) begin
      errors++; $display("FAIL dest0_ignored got slot1 %0d slot2 %0d want 0 0", d1, d2);
    end
    drive(1, 6, 1, 1, 0);  tick();
    drive(1, 12, 7, 1, 0); tick();
    checks++;
    if (r1 !== 5'd6 || d1 !== 5'd12 || rmask !== 6'b000001) begin
      errors++; $display("FAIL async_pre got rdest1 %0d slot1 %0d mask %b want 6 12 000001", r1, d1, rmask);
    end
    drive(0, 0, 0, 1, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (d1 !== 5'd0 || r1 !== 5'd0 || rmask !== 6'd0 || full !== 1'b0) begin
      errors++; $display("FAIL async_reset got slot1 %0d rdest1 %0d mask %b full %b want 0 0 0 0", d1, r1, rmask, full);
    end
    tick();
    rst = 1'b0;
    $display("test_dest0_async done");
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 9) < 6), $urandom_range(0, 31), $urandom_range(0, 7),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      tick();
      for (int k = 0; k < N; k++) begin
        checks++;
        if (dut_inf[k] !== 5'(m_dest[k]) || dut_rd[k] !== 5'(m_rdest[k])) begin
          errors++; $display("FAIL rand_slot%0d cycle%0d got dest %0d rdest %0d want %0d %0d",
                             k + 1, c, dut_inf[k], dut_rd[k], m_dest[k], m_rdest[k]);
        end
      end
      checks++;
      if (rmask !== m_mask || full !== (m_dest[0] != 0 && m_dest[1] != 0 && m_dest[2] != 0 &&
                                        m_dest[3] != 0 && m_dest[4] != 0 && m_dest[5] != 0)) begin
        errors++; $display("FAIL rand_flags cycle%0d got mask %b full %b want mask %b", c, rmask, full, m_mask);
      end
`ifdef FPU_INFLIGHT_CHECK_EN
      checks++;
      if (err !== m_err) begin
        errors++; $display("FAIL rand_error cycle%0d got %b want %b", c, err, m_err);
      end
`endif
    end
    $display("test_random done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_stall();
    test_fill_drop();
    test_back_to_back();
    test_flush();
    test_dest0_async();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
